// File: rtl/game_timer_ctrl_pkg.sv
// game_timer_ctrl_pkg: shared state encoding and clock constants for the round sequencer
package game_timer_ctrl_pkg;
    localparam int CLK_HZ = 100_000_000;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        SERVE  = 3'd2,
        PLAY   = 3'd3,
        PAUSED = 3'd4,
        OVER   = 3'd5
    } state_t;
endpackage

// File: rtl/game_timer_ctrl_if.sv
// game_timer_ctrl_if: buttons/game events in, timer control and status out
interface game_timer_ctrl_if #(parameter int ROUND_W = 4);
    logic               btn_start;
    logic               btn_pause;
    logic               point_scored;
    logic               clock_stopped;
    logic               timer_enable;
    logic               timer_reset;
    logic [2:0]         serve_count;
    logic [2:0]         state_o;
    logic               game_over;
    logic [ROUND_W-1:0] round_count;
    modport master (
        output btn_start, btn_pause, point_scored, clock_stopped,
        input  timer_enable, timer_reset, serve_count, state_o, game_over, round_count
    );
    modport slave (
        input  btn_start, btn_pause, point_scored, clock_stopped,
        output timer_enable, timer_reset, serve_count, state_o, game_over, round_count
    );
endinterface

// File: rtl/game_timer_ctrl_sec_prescaler.sv
// game_timer_ctrl_sec_prescaler: one-cycle tick every TICK_DIV enabled cycles
module game_timer_ctrl_sec_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && (cnt == CW'(TICK_DIV - 1));
    // wrap the count at TICK_DIV-1; clr restarts a fresh second
    always_ff @(posedge clk_100MHz) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: round sequencer gating the countdown timer through serve, play, pause and game over
module game_timer_ctrl
    import game_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = CLK_HZ,
    parameter int SERVE_SECS = 3
) (
    input  logic            clk_100MHz,
    input  logic            reset,
    game_timer_ctrl_if.slave bus
);
    state_t state, state_n;
    logic   start_q, pause_q, start_p, pause_p, tick;
    assign start_p     = bus.btn_start & ~start_q;
    assign pause_p     = bus.btn_pause & ~pause_q;
    assign bus.state_o = state;
    game_timer_ctrl_sec_prescaler #(.TICK_DIV(TICK_DIV)) u_serve_div (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clr        (state != SERVE),
        .en         (state == SERVE),
        .tick       (tick)
    );
    // next state: clock_stopped beats start, start beats point, point beats pause
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = start_p ? ARM : IDLE;
            ARM:     state_n = SERVE;
            SERVE:   state_n = (tick && bus.serve_count == 3'd1) ? PLAY : SERVE;
            PLAY:    state_n = bus.clock_stopped ? OVER : bus.point_scored ? SERVE : pause_p ? PAUSED : PLAY;
            PAUSED:  state_n = bus.clock_stopped ? OVER : start_p ? ARM : pause_p ? PLAY : PAUSED;
            OVER:    state_n = start_p ? ARM : OVER;
            default: state_n = IDLE;
        endcase
    end
    // state and registered outputs; button history tracks the level even in reset so a held button never counts as a press
    always_ff @(posedge clk_100MHz) begin
        start_q <= bus.btn_start;
        pause_q <= bus.btn_pause;
        if (reset) begin
            state            <= IDLE;
            bus.timer_enable <= 1'b0;
            bus.timer_reset  <= 1'b0;
            bus.serve_count  <= 3'd0;
            bus.game_over    <= 1'b0;
            bus.round_count  <= '0;
        end else begin
            state            <= state_n;
            bus.timer_enable <= (state == PLAY) && (state_n == PLAY);
            bus.timer_reset  <= state == ARM;
            bus.game_over    <= state_n == OVER;
            bus.serve_count  <= (state_n != SERVE) ? 3'd0 :
                                (state != SERVE)   ? 3'(SERVE_SECS) :
                                bus.serve_count - {2'd0, tick};
            bus.round_count  <= (state_n == ARM) ? '0 :
                                (state_n == SERVE && state != SERVE && !(&bus.round_count)) ? bus.round_count + 1'b1 :
                                bus.round_count;
        end
    end
endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: scoreboard bench walking serve, pause, point, game-over and reset scenarios
module tb_game_timer_ctrl;
    import game_timer_ctrl_pkg::*;
    typedef struct {
        bit    v;
        string tag;
        int    st;
        int    sc;
        int    rc;
        int    en;
        int    tr;
        int    go;
    } exp_t;
    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    exp_t sb[$];
    exp_t cur;
    game_timer_ctrl_if #(.ROUND_W(4)) bus ();
    game_timer_ctrl #(.TICK_DIV(10), .SERVE_SECS(3)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );
    always #5 clk_100MHz = ~clk_100MHz;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input bit v, input int st, sc, rc, en, tr, go);
        sb.push_back('{v, tag, st, sc, rc, en, tr, go});
        @(posedge clk_100MHz);
        #2;
    endtask
    task automatic serve_run(input string tag, input int rc);
        for (int k = 1; k < 30; k++) step(tag, 1, SERVE, 3 - k / 10, rc, 0, 0, 0);
        step({tag, "_play"}, 1, PLAY, 0, rc, 0, 0, 0);
        step({tag, "_en"}, 1, PLAY, 0, rc, 1, 0, 0);
    endtask
    // pop one expectation per clock and compare it with what the DUT registered
    always @(posedge clk_100MHz) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.v) begin
                chk({cur.tag, ".state"}, 32'(bus.state_o), cur.st);
                chk({cur.tag, ".serve"}, 32'(bus.serve_count), cur.sc);
                chk({cur.tag, ".round"}, 32'(bus.round_count), cur.rc);
                chk({cur.tag, ".en"}, 32'(bus.timer_enable), cur.en);
                chk({cur.tag, ".trst"}, 32'(bus.timer_reset), cur.tr);
                chk({cur.tag, ".over"}, 32'(bus.game_over), cur.go);
            end
        end
    end
    initial begin
        bus.btn_start     = 1'b0;
        bus.btn_pause     = 1'b0;
        bus.point_scored  = 1'b0;
        bus.clock_stopped = 1'b0;
        repeat (2) @(posedge clk_100MHz);
        #2;
        step("rst", 1, IDLE, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("idle", 1, IDLE, 0, 0, 0, 0, 0);
        bus.btn_start = 1'b1;
        step("arm", 1, ARM, 0, 0, 0, 0, 0);
        step("srv1_entry", 1, SERVE, 3, 1, 0, 1, 0);
        bus.btn_start = 1'b0;
        serve_run("srv1", 1);
        bus.btn_pause = 1'b1;
        step("pause", 1, PAUSED, 0, 1, 0, 0, 0);
        for (int i = 0; i < 49; i++) step("pause_held", 1, PAUSED, 0, 1, 0, 0, 0);
        bus.btn_pause = 1'b0;
        step("pause_rel", 1, PAUSED, 0, 1, 0, 0, 0);
        bus.btn_pause = 1'b1;
        step("resume", 1, PLAY, 0, 1, 0, 0, 0);
        step("resume_en", 1, PLAY, 0, 1, 1, 0, 0);
        bus.btn_pause = 1'b0;
        bus.btn_start = 1'b1;
        step("start_in_play", 1, PLAY, 0, 1, 1, 0, 0);
        bus.btn_start = 1'b0;
        step("play", 1, PLAY, 0, 1, 1, 0, 0);
        bus.point_scored = 1'b1;
        bus.btn_pause    = 1'b1;
        step("point_pause", 1, SERVE, 3, 2, 0, 0, 0);
        bus.point_scored = 1'b0;
        bus.btn_pause    = 1'b0;
        serve_run("srv2", 2);
        bus.clock_stopped = 1'b1;
        bus.point_scored  = 1'b1;
        step("stop_point", 1, OVER, 0, 2, 0, 0, 1);
        bus.point_scored = 1'b0;
        bus.btn_pause    = 1'b1;
        step("over_hold", 1, OVER, 0, 2, 0, 0, 1);
        bus.btn_pause = 1'b0;
        bus.btn_start = 1'b1;
        step("over_arm", 1, ARM, 0, 0, 0, 0, 0);
        step("srv3_entry", 1, SERVE, 3, 1, 0, 1, 0);
        bus.clock_stopped = 1'b0;
        for (int k = 1; k <= 10; k++) step("srv3", 1, SERVE, 3 - k / 10, 1, 0, 0, 0);
        reset = 1'b1;
        step("mid_rst", 1, IDLE, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("held_start", 1, IDLE, 0, 0, 0, 0, 0);
        step("held_start2", 1, IDLE, 0, 0, 0, 0, 0);
        bus.btn_start = 1'b0;
        step("idle_end", 1, IDLE, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
